// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS core memory port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_RESP
   } rsp_state_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Word storage for the memory responder: synchronous single-port array, no reset.
// Latency: one edge; read returns the pre-write contents of the addressed word.
// Backpressure: none; an access happens on every edge with en=1.
module mem_responder_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int DATA_W      = 32,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Read-before-write: a read never sees the word written on the same edge.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Slow memory model for the multicycle core: one word request at a time, fixed wait states, error flag.
// Latency: ready visible after the WAIT_STATES-th edge following acceptance (right after acceptance when 0).
// Backpressure: requests are only sampled in IDLE; busy stays high through WAIT and RESP.
module mem_responder
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam int         LANE_W  = $clog2(WORD_BYTES);
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
   localparam bit         NO_WAIT = (WAIT_STATES == 0);

   rsp_state_t        state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;

   logic              idle;
   logic              go_resp;
   logic              src_wr;
   logic              src_err;
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_wdata;
   logic [AW-1:0]     src_idx;
   logic [DATA_W-1:0] ram_rdata;

   // With no wait states the storage access happens on the accepting edge, so the live
   // inputs drive the array; otherwise the captured copies do.
   always_comb begin
      idle      = (state_q == RSP_IDLE);
      src_wr    = idle ? wr        : wr_q;
      src_addr  = idle ? Address   : addr_q;
      src_wdata = idle ? WriteData : wdata_q;
      src_idx   = src_addr[AW+LANE_W-1:LANE_W];
      src_err   = (src_addr[LANE_W-1:0] != '0) || ((src_addr >> (AW + LANE_W)) != '0);
      go_resp   = (idle && req && NO_WAIT) || (state_q == RSP_WAIT && cnt_q == 4'd1);
   end

   // Request sequencing: capture in IDLE, count wait states, one-cycle response.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= RSP_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            RSP_IDLE: begin
               if (req) begin
                  wr_q    <= wr;
                  addr_q  <= Address;
                  wdata_q <= WriteData;
                  if (NO_WAIT) begin
                     state_q <= RSP_RESP;
                  end else begin
                     state_q <= RSP_WAIT;
                     cnt_q   <= WS_INIT;
                  end
               end
            end
            RSP_WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q <= RSP_RESP;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= RSP_IDLE;
            end
         endcase
      end
   end

   // Error status is decided on the edge that enters RESP and held for the response cycle.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (go_resp) begin
         err_q <= src_err;
      end
   end

   mem_responder_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .DATA_W      (DATA_W),
      .AW          (AW)
   ) u_ram (
      .clk   (Clk),
      .en    (go_resp),
      .we    (go_resp && src_wr && !src_err),
      .addr  (src_idx),
      .wdata (src_wdata),
      .rdata (ram_rdata)
   );

   // Response outputs derive from state so reset clears them immediately.
   always_comb begin
      ready    = (state_q == RSP_RESP);
      err      = ready && err_q;
      busy     = (state_q != RSP_IDLE);
      ReadData = (ready && !err_q && !wr_q) ? ram_rdata : '0;
   end

endmodule
